ahb_sram_ctrl: RTL and testbench

AHB-Lite slave for synthesizable single-port SRAM; parametrised successor to the team's behavioural AHB RAM model, generalised in data width, depth and wait states. Adds a one-entry write buffer with read-after-write forwarding, so back-to-back reads and writes run at full rate on a single-port array. An optional ERROR response covers illegal accesses. Sits on the system AHB matrix as the on-chip RAM slave behind the decoder.

---
 rtl/ahb_sram_pkg.sv | 34 +++
 rtl/ahb_sram_if.sv | 26 ++
 rtl/ahb_sram_mem.sv | 27 ++
 rtl/ahb_sram_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_ahb_sram_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_sram_pkg.sv
// Shared AHB encodings, data-phase state type and byte-lane helper for the SRAM slave.
// AHB_SRAM_ERR_RESP_EN adds the two ERROR response states to the state type.
package ahb_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

`ifdef AHB_SRAM_ERR_RESP_EN
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} dp_state_t;
`else
    typedef enum logic [0:0] {ST_IDLE, ST_WAIT} dp_state_t;
`endif

    // Little-endian lanes; oversize transfers cover the whole bus, offsets align down to the size.
    function automatic logic [7:0] lane_mask(input logic [2:0] offset, input logic [2:0] size,
                                             input int lanes);
        int nbytes;
        int base;
        logic [15:0] ones;
        nbytes = 1 << size;
        if (nbytes > lanes) nbytes = lanes;
        ones = 16'((1 << nbytes) - 1);
        base = int'(offset) & ~(nbytes - 1) & (lanes - 1);
        return 8'(ones << base);
    endfunction

endpackage

// File: rtl/ahb_sram_if.sv
// AHB-Lite bus bundle between the system matrix (master side) and the SRAM slave.
interface ahb_sram_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          HSEL;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic [DW-1:0] HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic [DW-1:0] HRDATA;
    logic          HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRDATA, HRESP
    );
endinterface

// File: rtl/ahb_sram_mem.sv
// Single-port synchronous SRAM: one access per cycle, per-byte write enables, registered read.
module ahb_sram_mem #(
    parameter int DW        = 32,
    parameter int DEPTH     = 1024,
    parameter int IW        = 10,
    parameter     INIT_FILE = ""
) (
    input  logic            clk,
    input  logic            rd_en,
    input  logic [DW/8-1:0] wr_en,
    input  logic [IW-1:0]   addr,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   rdata
);
    logic [DW-1:0] ram [0:DEPTH-1];

    always_ff @(posedge clk) begin
        for (int b = 0; b < DW / 8; b++) begin
            if (wr_en[b]) ram[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) rdata <= ram[addr];
    end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite on-chip RAM slave with wait states and a one-entry write buffer with read forwarding.
// AHB_SRAM_ERR_RESP_EN enables ERROR responses for out-of-range, oversize and misaligned accesses.
module ahb_sram_ctrl
    import ahb_sram_pkg::*;
#(
    parameter int AW        = 16,
    parameter int DW        = 32,
    parameter int MEM_WORDS = 2 ** (AW - $clog2(DW / 8)),
    parameter int WS        = 0,
    parameter     INIT_FILE = ""
) (
    input  logic      HCLK,
    input  logic      HRESET,
    ahb_sram_if.slave bus
);
    localparam int LANES = DW / 8;
    localparam int LB    = $clog2(LANES);
    localparam int IW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic             accept;
    logic             err_now;
    logic             rd_en;
    logic             wr_acc;
    logic             wr_cpl;
    logic [31:0]      word_full;
    logic [IW-1:0]    word_idx;
    logic [LANES-1:0] req_mask;

    dp_state_t        state_reg;
    logic [2:0]       cnt_reg;
    logic             hreadyout_reg;
    logic             dp_write_reg;
    logic [IW-1:0]    dp_idx_reg;
    logic [LANES-1:0] dp_mask_reg;
    logic             rd_first_reg;
    logic [DW-1:0]    rdata_hold_reg;
    logic             wb_valid_reg;
    logic [IW-1:0]    wb_idx_reg;
    logic [LANES-1:0] wb_mask_reg;
    logic [DW-1:0]    wb_data_reg;

    logic             mem_rd;
    logic [LANES-1:0] mem_we;
    logic [IW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata;
    logic [DW-1:0]    fwd_data;
    logic             wb_hit;

    assign accept    = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign word_full = 32'(bus.HADDR >> LB);
    assign word_idx  = IW'(word_full % 32'(MEM_WORDS));
    assign req_mask  = LANES'(lane_mask(3'(bus.HADDR[LB-1:0]), bus.HSIZE, LANES));

`ifdef AHB_SRAM_ERR_RESP_EN
    logic          hresp_reg;
    logic [AW-1:0] align_mask;
    assign align_mask = AW'((32'd1 << bus.HSIZE) - 32'd1);
    assign err_now    = accept & ((word_full >= 32'(MEM_WORDS)) | (bus.HSIZE > 3'(LB)) |
                                  ((bus.HADDR & align_mask) != '0));
    assign bus.HRESP  = hresp_reg;
`else
    assign err_now    = 1'b0;
    assign bus.HRESP  = 1'b0;
`endif

    assign rd_en  = accept & ~bus.HWRITE & ~err_now;
    assign wr_acc = accept &  bus.HWRITE & ~err_now;
    assign wr_cpl = dp_write_reg & hreadyout_reg;

    // Port priority: new read, then the completing write, then the buffered write.
    always_comb begin
        mem_rd    = 1'b0;
        mem_we    = '0;
        mem_addr  = word_idx;
        mem_wdata = bus.HWDATA;
        if (rd_en) begin
            mem_rd = 1'b1;
        end else if (wr_cpl) begin
            mem_we   = dp_mask_reg;
            mem_addr = dp_idx_reg;
        end else if (wb_valid_reg) begin
            mem_we    = wb_mask_reg;
            mem_addr  = wb_idx_reg;
            mem_wdata = wb_data_reg;
        end
    end

    ahb_sram_mem #(
        .DW       (DW),
        .DEPTH    (MEM_WORDS),
        .IW       (IW),
        .INIT_FILE(INIT_FILE)
    ) u_mem (
        .clk  (HCLK),
        .rd_en(mem_rd),
        .wr_en(mem_we),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .rdata(mem_rdata)
    );

    // The array was read before any buffered write landed, so buffered lanes override it.
    assign wb_hit = wb_valid_reg && (wb_idx_reg == dp_idx_reg);
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_fwd
            assign fwd_data[gi*8 +: 8] = (wb_hit && wb_mask_reg[gi]) ? wb_data_reg[gi*8 +: 8]
                                                                     : mem_rdata[gi*8 +: 8];
        end
    endgenerate

    assign bus.HRDATA    = rd_first_reg ? fwd_data : rdata_hold_reg;
    assign bus.HREADYOUT = hreadyout_reg;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            hreadyout_reg <= 1'b1;
`ifdef AHB_SRAM_ERR_RESP_EN
            hresp_reg     <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_WAIT: begin
                    if (cnt_reg == 3'd1) begin
                        state_reg     <= ST_IDLE;
                        cnt_reg       <= '0;
                        hreadyout_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
`ifdef AHB_SRAM_ERR_RESP_EN
                ST_ERR1: begin
                    state_reg     <= ST_ERR2;
                    hreadyout_reg <= 1'b1;
                end
`endif
                default: begin
                    state_reg     <= ST_IDLE;
                    hreadyout_reg <= 1'b1;
`ifdef AHB_SRAM_ERR_RESP_EN
                    hresp_reg     <= 1'b0;
                    if (err_now) begin
                        state_reg     <= ST_ERR1;
                        hreadyout_reg <= 1'b0;
                        hresp_reg     <= 1'b1;
                    end else
`endif
                    if (accept && (WS > 0)) begin
                        state_reg     <= ST_WAIT;
                        cnt_reg       <= 3'(WS);
                        hreadyout_reg <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_write_reg   <= 1'b0;
            dp_idx_reg     <= '0;
            dp_mask_reg    <= '0;
            rd_first_reg   <= 1'b0;
            rdata_hold_reg <= '0;
            wb_valid_reg   <= 1'b0;
            wb_idx_reg     <= '0;
            wb_mask_reg    <= '0;
            wb_data_reg    <= '0;
        end else begin
            rd_first_reg <= rd_en;
            if (bus.HREADY) begin
                dp_write_reg <= wr_acc;
                if (accept) begin
                    dp_idx_reg  <= word_idx;
                    dp_mask_reg <= req_mask;
                end
            end
            if (rd_first_reg) rdata_hold_reg <= fwd_data;
`ifdef AHB_SRAM_ERR_RESP_EN
            // Overrides the previous read's capture: its data was already shown this cycle.
            if (err_now && !bus.HWRITE) rdata_hold_reg <= '0;
`endif
            if (wr_cpl && rd_en) begin
                wb_valid_reg <= 1'b1;
                wb_idx_reg   <= dp_idx_reg;
                wb_mask_reg  <= dp_mask_reg;
                wb_data_reg  <= bus.HWDATA;
            end else if (!rd_en && !wr_cpl) begin
                wb_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Scoreboard bench for ahb_sram_ctrl (DW=64, 256 words, WS=3); directed plus random AHB traffic.
// Expectations follow AHB_SRAM_ERR_RESP_EN when it is defined for the build.
module tb_ahb_sram_ctrl;
    import ahb_sram_pkg::*;

    localparam int AW = 16;
    localparam int DW = 64;
    localparam int MW = 256;
    localparam int WS = 3;

    logic HCLK = 1'b0;
    logic HRESET = 1'b1;
    always #5 HCLK = ~HCLK;

    ahb_sram_if #(.AW(AW), .DW(DW)) bus ();
    assign bus.HREADY = bus.HREADYOUT;

    ahb_sram_ctrl #(
        .AW(AW), .DW(DW), .MEM_WORDS(MW), .WS(WS), .INIT_FILE("")
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .bus(bus)
    );

    typedef struct {
        bit          rd;
        bit          err;
        logic [63:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ref_mem [0:MW-1][0:7];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_err(input logic [15:0] addr, input logic [2:0] size);
`ifdef AHB_SRAM_ERR_RESP_EN
        return (int'(addr) / 8 >= MW) || (size > 3) || (int'(addr) % (1 << size) != 0);
`else
        return 1'b0;
`endif
    endfunction

    // Reference: byte-addressed memory; word index wraps modulo the depth.
    task automatic model(input logic wr, input logic [15:0] addr, input logic [2:0] size,
                         input logic [63:0] wdata);
        exp_t e;
        int   idx;
        int   base;
        e.rd   = !wr;
        e.err  = is_err(addr, size);
        e.data = '0;
        idx    = (int'(addr) / 8) % MW;
        base   = int'(addr) % 8;
        if (!e.err) begin
            if (wr) begin
                for (int k = base; k < base + (1 << size); k++) ref_mem[idx][k] = wdata[8*k +: 8];
            end else begin
                for (int k = 0; k < 8; k++) e.data[8*k +: 8] = ref_mem[idx][k];
            end
        end
        sb.push_back(e);
    endtask

    task automatic xfer(input logic wr, input logic [15:0] addr, input logic [2:0] size,
                        input logic [63:0] wdata);
        bit ok;
        bus.HSEL   = 1'b1;
        bus.HTRANS = ($urandom_range(0, 1) != 0) ? HTRANS_SEQ : HTRANS_NONSEQ;
        bus.HADDR  = addr;
        bus.HWRITE = wr;
        bus.HSIZE  = size;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge HCLK);
            if (bus.HREADY) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            $display("FAIL hready_timeout: got HREADY=0 for 20 cycles expected 1");
            $fatal(1, "bus stuck");
        end
        @(posedge HCLK);
        #1;
        model(wr, addr, size, wdata);
        if (wr) bus.HWDATA = wdata;
        bus.HTRANS = HTRANS_IDLE;
        bus.HSEL   = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.HTRANS = HTRANS_IDLE;
        bus.HSEL   = 1'b0;
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    // Monitor: pops one expectation per completed data phase, checks waits, HRESP and HRDATA.
    initial begin
        bit   dp_pending;
        int   wait_cnt;
        exp_t e;
        dp_pending = 1'b0;
        wait_cnt   = 0;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                dp_pending = 1'b0;
                wait_cnt   = 0;
            end else begin
                if (dp_pending) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 64'd1, 64'd0);
                    end else if (!bus.HREADYOUT) begin
                        wait_cnt++;
                        chk("resp_wait", 64'(bus.HRESP), 64'(sb[0].err));
                    end else begin
                        e = sb.pop_front();
                        chk("resp", 64'(bus.HRESP), 64'(e.err));
                        chk("waits", 64'(wait_cnt), e.err ? 64'd1 : 64'(WS));
                        if (e.rd) chk("rdata", bus.HRDATA, e.data);
                        $display("xfer %s err=%0d waits=%0d hrdata=%h", e.rd ? "RD" : "WR",
                                 e.err, wait_cnt, bus.HRDATA);
                        wait_cnt = 0;
                    end
                end
                dp_pending = (dp_pending && !bus.HREADYOUT) ? 1'b1
                           : (bus.HSEL & bus.HREADY & bus.HTRANS[1]);
            end
        end
    end

    // The write buffer must never be asked to hold a second entry.
    always @(negedge HCLK) begin
        if (!HRESET && dut.wb_valid_reg && dut.rd_en && dut.wr_cpl) begin
            errors++;
            $display("FAIL wb_single: got second buffered write expected at most one");
        end
    end

    initial begin
        logic       wr;
        logic [2:0] sz;
        logic [15:0] a;
        int         n;

        bus.HSEL = 1'b0; bus.HTRANS = HTRANS_IDLE; bus.HADDR = '0;
        bus.HWRITE = 1'b0; bus.HSIZE = HSIZE_BYTE; bus.HWDATA = '0;
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_hreadyout", 64'(bus.HREADYOUT), 64'd1);
        chk("rst_hresp", 64'(bus.HRESP), 64'd0);
        chk("rst_hrdata", bus.HRDATA, 64'd0);
        HRESET = 1'b0;
        idle(1);

        for (int w = 0; w < MW; w++) xfer(1'b1, 16'(w * 8), HSIZE_DWORD, {$urandom, $urandom});
        idle(2);

        xfer(1'b1, 16'h0010, HSIZE_WORD, 64'h0000_0000_DEAD_BEEF);
        xfer(1'b0, 16'h0010, HSIZE_WORD, '0);
        xfer(1'b1, 16'h0021, HSIZE_BYTE, 64'h0000_0000_0000_AA00);
        xfer(1'b0, 16'h0020, HSIZE_WORD, '0);
        idle(3);
        xfer(1'b0, 16'h0020, HSIZE_WORD, '0);
        xfer(1'b1, 16'h0006, HSIZE_HALF, 64'h1234_0000_0000_0000);
        xfer(1'b0, 16'h0000, HSIZE_DWORD, '0);
        xfer(1'b1, 16'h0800, HSIZE_DWORD, 64'h0123_4567_89AB_CDEF);
        xfer(1'b0, 16'h0000, HSIZE_DWORD, '0);
`ifdef AHB_SRAM_ERR_RESP_EN
        xfer(1'b0, 16'h0800, HSIZE_DWORD, '0);
        xfer(1'b1, 16'h0002, HSIZE_WORD, 64'hFFFF_FFFF_FFFF_FFFF);
        xfer(1'b0, 16'h0000, HSIZE_DWORD, '0);
        xfer(1'b0, 16'h0010, 3'd4, '0);
`endif
        idle(2);

        for (int i = 0; i < 300; i++) begin
            wr = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
`ifdef AHB_SRAM_ERR_RESP_EN
            if ($urandom_range(0, 7) == 0) sz = 3'($urandom_range(4, 7));
            if ($urandom_range(0, 3) != 0) a = a & ~16'((1 << sz) - 1);
`else
            a = a & ~16'((1 << sz) - 1);
`endif
            xfer(wr, a, sz, {$urandom, $urandom});
            if ($urandom_range(0, 4) == 0) idle(1);
        end

        // Reset during a wait state; the array keeps its contents.
        idle(4);
        xfer(1'b0, 16'h0010, HSIZE_DWORD, '0);
        @(posedge HCLK);
        #1;
        chk("wait_before_rst", 64'(bus.HREADYOUT), 64'd0);
        HRESET = 1'b1;
        #1;
        chk("rst_mid_hreadyout", 64'(bus.HREADYOUT), 64'd1);
        chk("rst_mid_hresp", 64'(bus.HRESP), 64'd0);
        chk("rst_mid_hrdata", bus.HRDATA, 64'd0);
        @(negedge HCLK);
        #1;
        sb.delete();
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        idle(2);
        xfer(1'b0, 16'h0010, HSIZE_DWORD, '0);
        xfer(1'b0, 16'h0020, HSIZE_DWORD, '0);

        idle(1);
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge HCLK);
            n++;
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
